// File: rtl/rc_req_dispatcher_if.sv
// Request bus between the dispatcher and the transaction-ID slots.
// master drives en/trid/request fields; slave returns per-slot ready.
interface rc_req_dispatcher_if #(
    parameter int ADDR_W    = 32,
    parameter int NUM_TRID  = 16,
    parameter int TRID_W    = $clog2(NUM_TRID),
    parameter int BUS_BYTES = 16,
    parameter int BUS_BIT   = $clog2(BUS_BYTES) + 1,
    parameter int MAXB_W    = 3
);
    logic [NUM_TRID-1:0] ready;
    logic [NUM_TRID-1:0] en;
    logic [TRID_W-1:0]   trid;
    logic [ADDR_W-1:0]   r_addr;
    logic [MAXB_W-1:0]   r_beats;
    logic [BUS_BIT-1:0]  r_start;
    logic [BUS_BIT-1:0]  r_end;
    logic [ADDR_W-1:0]   w_addr;
    logic [6:0]          w_size;

    modport master (
        input  ready,
        output en, trid, r_addr, r_beats,
        output r_start, r_end, w_addr, w_size
    );

    modport slave (
        output ready,
        input  en, trid, r_addr, r_beats,
        input  r_start, r_end, w_addr, w_size
    );
endinterface

// File: rtl/rc_req_dispatcher.sv
// Walks table rows and issues one column read request per row to a free
// transaction-ID slot chosen round-robin.
// Ports: i_clk, i_rst (sync, active high), i_start/i_abort control,
// config (i_base_addr, i_row_size, i_row_cnt, i_col_offset, i_col_width,
// i_dst_base), bus (request interface, master), o_busy, o_done.
module rc_req_dispatcher #(
    parameter int ADDR_W    = 32,
    parameter int NUM_TRID  = 16,
    parameter int TRID_W    = $clog2(NUM_TRID),
    parameter int BUS_BYTES = 16,
    parameter int BUS_BIT   = $clog2(BUS_BYTES) + 1,
    parameter int MAXB_W    = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_row_size,
    input  logic [ADDR_W-1:0] i_row_cnt,
    input  logic [15:0]       i_col_offset,
    input  logic [6:0]        i_col_width,
    input  logic [ADDR_W-1:0] i_dst_base,
    rc_req_dispatcher_if.master bus,
    output logic              o_busy,
    output logic              o_done
);
    localparam int LOG_BB = $clog2(BUS_BYTES);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BUS_BYTES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   row_size_q;
    logic [ADDR_W-1:0]   row_cnt_q;
    logic [6:0]          width_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W-1:0]   row_q;
    logic [TRID_W-1:0]   rr_q;

    logic [NUM_TRID-1:0] en_q;
    logic [TRID_W-1:0]   trid_q;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [MAXB_W-1:0]   r_beats_q;
    logic [BUS_BIT-1:0]  r_start_q;
    logic [BUS_BIT-1:0]  r_end_q;
    logic [ADDR_W-1:0]   w_addr_q;
    logic [6:0]          w_size_q;

    logic [NUM_TRID-1:0] eligible;
    logic                found;
    logic [TRID_W-1:0]   grant;
    logic                take;
    logic [6:0]          width_in;
    logic [ADDR_W-1:0]   lane;
    logic [ADDR_W-1:0]   last;
    logic [ADDR_W-1:0]   beats;

    // Masking the previous grant hides the slot's one-cycle ready lag.
    assign eligible = bus.ready & ~en_q;
    assign width_in = (i_col_width == 7'd0) ? 7'd1 : i_col_width;

    assign lane  = src_q & LANE_MASK;
    assign last  = lane + ADDR_W'(width_q) - ADDR_W'(1);
    assign beats = (last >> LOG_BB) + ADDR_W'(1);

    // First eligible slot at or after rr_q, circularly.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_TRID; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NUM_TRID;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                grant = TRID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start)
                    state_d = (i_row_cnt == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (found) begin
                    take = 1'b1;
                    if (row_q == row_cnt_q - ADDR_W'(1))
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            row_size_q <= '0;
            row_cnt_q  <= '0;
            width_q    <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            row_q      <= '0;
            rr_q       <= '0;
            en_q       <= '0;
            trid_q     <= '0;
            r_addr_q   <= '0;
            r_beats_q  <= '0;
            r_start_q  <= '0;
            r_end_q    <= '0;
            w_addr_q   <= '0;
            w_size_q   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state_q <= state_d;
            o_busy  <= (state_d != IDLE);
            o_done  <= (state_q == DONE) && !i_abort;
            en_q    <= take ? (NUM_TRID'(1) << grant) : '0;

            if (state_q == IDLE && i_start) begin
                row_size_q <= i_row_size;
                row_cnt_q  <= i_row_cnt;
                width_q    <= width_in;
                src_q      <= i_base_addr + ADDR_W'(i_col_offset);
                dst_q      <= i_dst_base;
                row_q      <= '0;
            end

            if (take) begin
                trid_q    <= grant;
                r_addr_q  <= src_q & ~LANE_MASK;
                r_beats_q <= MAXB_W'(beats);
                r_start_q <= BUS_BIT'(lane);
                r_end_q   <= BUS_BIT'(last & LANE_MASK);
                w_addr_q  <= dst_q;
                w_size_q  <= width_q;
                rr_q      <= (grant == TRID_W'(NUM_TRID - 1)) ?
                             '0 : grant + TRID_W'(1);
                row_q     <= row_q + ADDR_W'(1);
                src_q     <= src_q + row_size_q;
                dst_q     <= dst_q + ADDR_W'(width_q);
            end
        end
    end

    assign bus.en      = en_q;
    assign bus.trid    = trid_q;
    assign bus.r_addr  = r_addr_q;
    assign bus.r_beats = r_beats_q;
    assign bus.r_start = r_start_q;
    assign bus.r_end   = r_end_q;
    assign bus.w_addr  = w_addr_q;
    assign bus.w_size  = w_size_q;
endmodule
